// File: rtl/sdram_rd_frontend.sv
// SDRAM burst-read front end: request FIFO, one-at-a-time engine handshake, buffered response.
// Optional issue-to-finish watchdog is compiled in when RD_FRONTEND_TIMEOUT_EN is defined.
module sdram_rd_frontend #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         iclk,
    input  logic         ctr_reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [24:0]  req_addr,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    input  logic         refresh_pend,
    output logic         eng_req,
    output logic         eng_enb,
    output logic [1:0]   eng_bank,
    output logic [12:0]  eng_row,
    output logic [9:0]   eng_column,
    input  logic         eng_fin,
    input  logic [127:0] eng_data,
    output logic         busy
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("sdram_rd_frontend: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef struct packed {
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  column;
    } rd_req_t;

    typedef enum logic [1:0] { IDLE, ISSUE, WAIT_FIN, RESP } state_t;

    rd_req_t     fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;
    rd_req_t     head;
    state_t      state;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && !empty && !refresh_pend;
    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE);

    always_ff @(posedge iclk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= rd_req_t'(req_addr);
    end

    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

`ifdef RD_FRONTEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            state      <= IDLE;
            eng_req    <= 1'b0;
            eng_enb    <= 1'b0;
            eng_bank   <= '0;
            eng_row    <= '0;
            eng_column <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
`ifdef RD_FRONTEND_TIMEOUT_EN
            rsp_err    <= 1'b0;
            tmo_cnt    <= '0;
`endif
        end else begin
            eng_req <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    state      <= ISSUE;
                    eng_req    <= 1'b1;
                    eng_enb    <= 1'b1;
                    eng_bank   <= head.bank;
                    eng_row    <= head.row;
                    eng_column <= head.column & 10'h3F8;  // bursts are 8-word aligned
                end
                ISSUE: begin
                    state <= WAIT_FIN;
`ifdef RD_FRONTEND_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT_FIN: if (eng_fin) begin
                    state     <= RESP;
                    eng_enb   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= eng_data;
`ifdef RD_FRONTEND_TIMEOUT_EN
                    rsp_err   <= 1'b0;
                end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    // Expiry on the TIMEOUT_CYC-th wait cycle; a same-cycle finish takes the branch above.
                    state     <= RESP;
                    eng_enb   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
`endif
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
